// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared status codes, glyphs and display state for the calculator display path
package calc_pkg;

  localparam logic [1:0] ST_ERRO  = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_READY = 2'b10;
  localparam logic [1:0] ST_PRINT = 2'b11;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_O     = 7'h23;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ERROR
  } disp_state_t;

  // Leading zeros from index 7 downward are blanked; any nonzero code (incl. 10-15) ends the run.
  function automatic logic [7:0] lz_blank_mask(input logic [7:0][3:0] digits);
    logic [7:0] m;
    logic       run;
    m   = '0;
    run = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      if (run && (digits[i] == 4'd0)) m[i] = 1'b1;
      else run = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/calc_display_seg7_decoder.sv
// rtl/calc_display_seg7_decoder.sv - BCD / error-letter to active-low 7-segment glyph
module seg7_decoder
  import calc_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       blank_i,
  input  logic       err_i,
  output logic [6:0] seg_o
);

  // In error mode code_i carries the digit index, which selects the letter of "Erro".
  always_comb begin
    seg_o = SEG_BLANK;
    if (err_i) begin
      case (code_i)
        4'd3:    seg_o = SEG_E;
        4'd2:    seg_o = SEG_R;
        4'd1:    seg_o = SEG_R;
        4'd0:    seg_o = SEG_O;
        default: seg_o = SEG_BLANK;
      endcase
    end else if (!blank_i) begin
      case (code_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/calc_display.sv
// rtl/calc_display.sv - captures the core digit stream into a frame and scans an 8-digit display
module calc_display
  import calc_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] status,
  input  logic [3:0] data,
  input  logic [3:0] pos,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       loading,
  output logic [7:0] frame_cnt
);

  localparam int         CNT_W       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [7:0] RESET_BLANK = BLANK_LZ ? 8'hFE : 8'h00;

  disp_state_t     state_q;
  logic [7:0][3:0] shadow_q, disp_q, commit_d;
  logic [7:0]      mask_q, blank_q, blank_d;
  logic [7:0]      frame_cnt_q, an_q;
  logic [CNT_W-1:0] refresh_q;
  logic [2:0]      scan_idx_q;
  logic [6:0]      seg_q, seg_d;
  logic            loading_q;
  logic            pos_ok;
  logic [2:0]      wr_idx;
  logic [3:0]      dec_code;

  assign pos_ok = (status == ST_PRINT) && (pos >= 4'd1) && (pos <= 4'd8);
  assign wr_idx = 3'(pos - 4'd1);

  always_comb begin
    commit_d = '0;
    for (int i = 0; i < 8; i++) commit_d[i] = mask_q[i] ? shadow_q[i] : 4'd0;
    blank_d = BLANK_LZ ? lz_blank_mask(commit_d) : 8'h00;
  end

  assign dec_code = (state_q == S_ERROR) ? {1'b0, scan_idx_q} : disp_q[scan_idx_q];

  seg7_decoder u_dec (
    .code_i  (dec_code),
    .blank_i (blank_q[scan_idx_q]),
    .err_i   (state_q == S_ERROR),
    .seg_o   (seg_d)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shadow_q    <= '0;
      mask_q      <= '0;
      disp_q      <= '0;
      blank_q     <= RESET_BLANK;
      frame_cnt_q <= '0;
      refresh_q   <= '0;
      scan_idx_q  <= '0;
      an_q        <= 8'hFF;
      seg_q       <= SEG_BLANK;
      loading_q   <= 1'b0;
    end else begin
      if (refresh_q == CNT_W'(REFRESH_DIV - 1)) begin
        refresh_q  <= '0;
        scan_idx_q <= scan_idx_q + 3'd1;
      end else begin
        refresh_q <= refresh_q + 1'b1;
      end
      an_q  <= ~(8'b1 << scan_idx_q);
      seg_q <= seg_d;

      if (status == ST_ERRO) begin
        state_q   <= S_ERROR;
        loading_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            // The digit presented on the entry edge is already part of the new frame.
            if (status == ST_PRINT) begin
              state_q   <= S_LOAD;
              loading_q <= 1'b1;
              shadow_q  <= '0;
              mask_q    <= '0;
              if (pos_ok) begin
                shadow_q[wr_idx] <= data;
                mask_q[wr_idx]   <= 1'b1;
              end
            end
          end
          S_LOAD: begin
            case (status)
              ST_PRINT: begin
                if (pos_ok) begin
                  shadow_q[wr_idx] <= data;
                  mask_q[wr_idx]   <= 1'b1;
                end
              end
              ST_READY: begin
                disp_q      <= commit_d;
                blank_q     <= blank_d;
                frame_cnt_q <= frame_cnt_q + 8'd1;
                state_q     <= S_IDLE;
                loading_q   <= 1'b0;
              end
              ST_BUSY: ;
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = 1'b1;
  assign loading   = loading_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_calc_display.sv
// tb/tb_calc_display.sv - directed self-checking bench for calc_display
module tb_calc_display;
  import calc_pkg::*;

  logic       clock;
  logic       reset;
  logic [1:0] status;
  logic [3:0] data;
  logic [3:0] pos;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       loading;
  logic [7:0] frame_cnt;

  int n_vec;
  int n_err;

  logic [6:0] seen [8];
  logic [6:0] expv [8];

  calc_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clock     (clock),
    .reset     (reset),
    .status    (status),
    .data      (data),
    .pos       (pos),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .loading   (loading),
    .frame_cnt (frame_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic drive(input logic [1:0] st, input logic [3:0] p, input logic [3:0] d);
    status = st;
    pos    = p;
    data   = d;
    @(negedge clock);
  endtask

  task automatic capture_scan();
    for (int i = 0; i < 8; i++) seen[i] = 7'h55;
    for (int c = 0; c < 36; c++) begin
      @(negedge clock);
      for (int i = 0; i < 8; i++) if (an == ~(8'b1 << i)) seen[i] = seg;
    end
  endtask

  task automatic test_reset();
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    int         idx;
    reset = 1'b1;
    status = ST_READY; pos = 4'd0; data = 4'd0;
    repeat (3) @(negedge clock);
    n_vec++; if (an !== 8'hFF) begin n_err++; $display("FAIL reset_an: got %h expected ff", an); end
    n_vec++; if (seg !== 7'h7F) begin n_err++; $display("FAIL reset_seg: got %h expected 7f", seg); end
    n_vec++; if (dp !== 1'b1) begin n_err++; $display("FAIL reset_dp: got %b expected 1", dp); end
    n_vec++; if (loading !== 1'b0) begin n_err++; $display("FAIL reset_loading: got %b expected 0", loading); end
    n_vec++; if (frame_cnt !== 8'd0) begin n_err++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
    reset = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      idx     = ((k - 1) / 4) % 8;
      exp_an  = ~(8'b1 << idx);
      exp_seg = (idx == 0) ? 7'h40 : 7'h7F;
      n_vec++; if (an !== exp_an) begin n_err++; $display("FAIL idle_an[%0d]: got %h expected %h", k, an, exp_an); end
      n_vec++; if (seg !== exp_seg) begin n_err++; $display("FAIL idle_seg[%0d]: got %h expected %h", k, seg, exp_seg); end
    end
    n_vec++; if (frame_cnt !== 8'd0) begin n_err++; $display("FAIL idle_frame_cnt: got %0d expected 0", frame_cnt); end
  endtask

  task automatic test_commit();
    logic [3:0] digs [8];
    digs = '{4'd5, 4'd0, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    for (int i = 0; i < 8; i++) drive(ST_PRINT, 4'(i + 1), digs[i]);
    drive(ST_READY, 4'd0, 4'd0);
    n_vec++; if (frame_cnt !== 8'd1) begin n_err++; $display("FAIL commit_frame_cnt: got %0d expected 1", frame_cnt); end
    n_vec++; if (loading !== 1'b0) begin n_err++; $display("FAIL commit_loading: got %b expected 0", loading); end
    capture_scan();
    expv = '{7'h12, 7'h40, 7'h30, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (seen[i] !== expv[i]) begin n_err++; $display("FAIL commit_seg[%0d]: got %h expected %h", i, seen[i], expv[i]); end
    end
  endtask

  task automatic test_midstream();
    drive(ST_PRINT, 4'd1, 4'd9);
    drive(ST_PRINT, 4'd2, 4'd8);
    drive(ST_PRINT, 4'd3, 4'd7);
    drive(ST_PRINT, 4'd4, 4'd6);
    n_vec++; if (loading !== 1'b1) begin n_err++; $display("FAIL mid_loading: got %b expected 1", loading); end
    capture_scan();
    expv = '{7'h12, 7'h40, 7'h30, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (seen[i] !== expv[i]) begin n_err++; $display("FAIL mid_old_seg[%0d]: got %h expected %h", i, seen[i], expv[i]); end
    end
    n_vec++; if (frame_cnt !== 8'd1) begin n_err++; $display("FAIL mid_frame_cnt: got %0d expected 1", frame_cnt); end
    for (int p = 5; p <= 8; p++) drive(ST_PRINT, 4'(p), 4'd0);
    drive(ST_READY, 4'd0, 4'd0);
    n_vec++; if (frame_cnt !== 8'd2) begin n_err++; $display("FAIL mid_commit_frame_cnt: got %0d expected 2", frame_cnt); end
    capture_scan();
    expv = '{7'h10, 7'h00, 7'h78, 7'h02, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (seen[i] !== expv[i]) begin n_err++; $display("FAIL mid_new_seg[%0d]: got %h expected %h", i, seen[i], expv[i]); end
    end
  endtask

  task automatic test_out_of_range_dup();
    drive(ST_PRINT, 4'd0, 4'd3);
    drive(ST_PRINT, 4'd1, 4'd1);
    drive(ST_PRINT, 4'd9, 4'd4);
    drive(ST_PRINT, 4'd2, 4'd7);
    drive(ST_PRINT, 4'd2, 4'd8);
    drive(ST_READY, 4'd0, 4'd0);
    n_vec++; if (frame_cnt !== 8'd3) begin n_err++; $display("FAIL dup_frame_cnt: got %0d expected 3", frame_cnt); end
    capture_scan();
    expv = '{7'h79, 7'h00, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (seen[i] !== expv[i]) begin n_err++; $display("FAIL dup_seg[%0d]: got %h expected %h", i, seen[i], expv[i]); end
    end
  endtask

  task automatic test_error();
    drive(ST_ERRO, 4'd0, 4'd0);
    n_vec++; if (loading !== 1'b0) begin n_err++; $display("FAIL err_loading: got %b expected 0", loading); end
    drive(ST_PRINT, 4'd1, 4'd5);
    drive(ST_PRINT, 4'd2, 4'd6);
    drive(ST_READY, 4'd0, 4'd0);
    capture_scan();
    expv = '{7'h23, 7'h2F, 7'h2F, 7'h06, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (seen[i] !== expv[i]) begin n_err++; $display("FAIL err_seg[%0d]: got %h expected %h", i, seen[i], expv[i]); end
    end
    n_vec++; if (frame_cnt !== 8'd3) begin n_err++; $display("FAIL err_frame_cnt: got %0d expected 3", frame_cnt); end
  endtask

  task automatic test_reset_in_load();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    drive(ST_PRINT, 4'd1, 4'd5);
    drive(ST_PRINT, 4'd2, 4'd6);
    status = ST_PRINT; pos = 4'd3; data = 4'd7;
    @(posedge clock);
    #1;
    n_vec++; if (loading !== 1'b1) begin n_err++; $display("FAIL rl_loading_pre: got %b expected 1", loading); end
    reset = 1'b1;
    #1;
    n_vec++; if (an !== 8'hFF) begin n_err++; $display("FAIL rl_an: got %h expected ff", an); end
    n_vec++; if (seg !== 7'h7F) begin n_err++; $display("FAIL rl_seg: got %h expected 7f", seg); end
    n_vec++; if (loading !== 1'b0) begin n_err++; $display("FAIL rl_loading: got %b expected 0", loading); end
    n_vec++; if (frame_cnt !== 8'd0) begin n_err++; $display("FAIL rl_frame_cnt: got %0d expected 0", frame_cnt); end
    @(negedge clock);
    reset = 1'b0;
    status = ST_READY; pos = 4'd0; data = 4'd0;
    capture_scan();
    expv = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (seen[i] !== expv[i]) begin n_err++; $display("FAIL rl_seg_after[%0d]: got %h expected %h", i, seen[i], expv[i]); end
    end
    n_vec++; if (frame_cnt !== 8'd0) begin n_err++; $display("FAIL rl_frame_cnt_after: got %0d expected 0", frame_cnt); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    status = ST_READY;
    pos = 4'd0;
    data = 4'd0;
    test_reset();
    test_commit();
    test_midstream();
    test_out_of_range_dup();
    test_error();
    test_reset_in_load();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/calc_display.md
# calc_display

Receive side of the calculator's digit-print stream. Captures the `(status, data, pos)` sequence the calculator core emits one digit per cycle, assembles it into an 8-digit frame, commits the frame atomically when printing ends, and drives a time-multiplexed 8-digit common-anode 7-segment display. It also applies leading-zero blanking and a sticky error pattern.

## Interface
Parameters:
- `REFRESH_DIV`, default 50000: clock cycles each digit is lit during scanning; legal range ≥ 2.
- `BLANK_LZ`, default 1: 1 enables leading-zero blanking; 0 shows all 8 digits.

Ports:
- `clock`: input, 1 bit. Single clock.
- `reset`: input, 1 bit. Asynchronous, active-high.
- `status`: input, 2 bits. Core status: 00 error, 01 busy, 10 ready, 11 printing.
- `data`: input, 4 bits. BCD digit from the core.
- `pos`: input, 4 bits. Core position counter; `data` belongs to digit index `pos-1`.
- `an`: output, 8 bits. Anode enables, active-low, one-hot-zero while scanning.
- `seg`: output, 7 bits. Segments `{g,f,e,d,c,b,a}`, active-low.
- `dp`: output, 1 bit. Decimal point, active-low; always 1 (off).
- `loading`: output, 1 bit. High while in LOAD.
- `frame_cnt`: output, 8 bits. Count of committed frames; wraps at 255→0.

## Operation
- States: IDLE, LOAD, ERROR. Reset enters IDLE.
- IDLE → LOAD when `status==11`. On entry, clear the shadow buffer (8×4 bits) and the 8-bit written-mask.
- In LOAD, when `status==11` and `1≤pos≤8`:
  - `shadow[pos-1] <= data`.
  - Set `mask[pos-1]`.
  - Writes with `pos==0` or `pos>8` are ignored.
  - Repeated writes to the same index: last value wins.
- LOAD → IDLE when `status==10` (commit):
  - `disp <= shadow`. Unwritten positions hold 0.
  - `frame_cnt++`.
  - Recompute the blank mask in the same edge.
- LOAD with `status==01`: stay in LOAD, no write.
- Any state → ERROR when `status==00`. ERROR is sticky; only `reset` leaves it.
- Blank mask (when `BLANK_LZ=1`): scanning from index 7 down, blank each digit equal to 0 until the first nonzero digit. Index 0 is never blanked.
- `disp` values 10–15 render blank and stop the leading-zero scan.
- ERROR display: indices 7..4 blank; indices 3,2,1,0 show E, r, r, o.
- Glyphs (active-low `seg`):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - E=06, r=2F, o=23, blank=7F.
- Scanning:
  - `refresh_cnt` counts 0..REFRESH_DIV-1. On wrap, `scan_idx` increments 0..7, and 7 wraps to 0.
  - `an = ~(8'b1 << scan_idx)`.
  - `seg` = glyph of `disp[scan_idx]`, or blank per the blank mask, or the error glyph in ERROR.

## Timing
- Reset values:
  - State IDLE, `an=FF`, `seg=7F`, `dp=1`, `loading=0`, `frame_cnt=0`.
  - `disp`, `shadow`, `mask`, `refresh_cnt`, `scan_idx` all 0.
  - Blank mask reset value: 7 leading digits blanked, so the first scan shows "0" on index 0.
- `an`, `seg`, and `loading` are registered. `an`/`seg` update one cycle after `scan_idx` changes. `an` leaves FF on the first cycle after reset deasserts.
- Input sampling: capture happens on the edge where `status==11` and `pos` is valid. The core delivers one digit per cycle; there is no back-pressure.
- Commit latency: `disp` is updated on the edge sampling `status==10`. The new frame appears on `seg` at the next cycle in which the affected index is scanned.
- A frame in progress is never visible: `disp` changes only at commit.
- Entering ERROR takes effect on the edge sampling `status==00`. `seg` shows the error pattern one cycle later.
- Reset during LOAD: the partial frame is discarded, all state returns to reset values, and `frame_cnt` is unchanged at 0.
- `status==10` while in IDLE has no effect.

## Structure
- Shared package `calc_pkg` holds:
  - Status encodings `ST_ERRO=2'b00`, `ST_BUSY=2'b01`, `ST_READY=2'b10`, `ST_PRINT=2'b11`.
  - The glyph constants.
  - The state enum `disp_state_t`.
  - The core should be migrated to the same status constants.
- One sub-module, `seg7_decoder`: purely combinational, 4-bit code plus blank/error-select in, 7-bit active-low segments out.

## Test plan
All scenarios run with `REFRESH_DIV=4` and `BLANK_LZ=1`.
- Reset, then idle 40 cycles → index 0 shows 40 (hex), indices 1–7 show 7F, `an` cycles FE, FD, …, 7F every 4 cycles, `frame_cnt=0`.
- Stream value 305 (`status=11`; `pos` 1..8 with `data` 5,0,3,0,0,0,0,0), then `status=10` → index 0 shows 12 (5), index 1 shows 40 (0), index 2 shows 30 (3), indices 3–7 show 7F, `frame_cnt=1`.
- Mid-stream check after `pos=4` → `seg` still shows the previous frame and `loading=1`; after commit, the new frame appears.
- `status=00` at any time → indices 3..0 show 06, 2F, 2F, 23 and indices 7..4 show 7F; the pattern persists through later `status=11`/`10` traffic until `reset`.
- Assert `reset` during LOAD at `pos=3` → `an=FF`, `seg=7F` immediately; the display afterwards shows "0" and `frame_cnt=0`.
- Stream with `pos=0` and `pos=9` writes interleaved, plus a duplicate `pos=2` write (7 then 8) → the out-of-range writes are ignored and index 1 shows 00 (8).
